// File: rtl/boot_loader_ctl_if.sv
// Bus bundle between the boot sequencer (master), the boot ROM read port and
// the RAM write port (slave side).
interface boot_loader_ctl_if;
  logic [14:0] rom_addr;
  logic        rom_rd;
  logic [11:0] rom_data;
  logic [14:0] ram_addr;
  logic [11:0] ram_data;
  logic        ram_wr;
  logic        ram_ack;

  modport master (
    output rom_addr, rom_rd, ram_addr, ram_data, ram_wr,
    input  rom_data, ram_ack
  );

  modport slave (
    input  rom_addr, rom_rd, ram_addr, ram_data, ram_wr,
    output rom_data, ram_ack
  );
endinterface

// File: rtl/boot_loader_ctl.sv
// Boot sequencer: copies LEN words from the boot ROM into RAM, then releases the CPU.
// Define BOOT_CHECKSUM_EN to verify a 12-bit sum of the copied words before release.
module boot_loader_ctl #(
  parameter logic [14:0] SRC_BASE = 15'o07400,
  parameter logic [14:0] DST_BASE = 15'o00020,
  parameter int          LEN      = 21,
  parameter logic [14:0] START_PC = 15'o00020,
  parameter int          TIMEOUT  = 16
`ifdef BOOT_CHECKSUM_EN
  ,
  parameter logic [11:0] CHECKSUM = 12'o0000
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  boot_loader_ctl_if.master  bus,
  output logic               busy,
  output logic               cpu_run,
  output logic [14:0]        cpu_pc,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [11:0]       LAST_IDX  = 12'(LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [11:0]       idx_q, idx_d;
  logic [11:0]       data_q, data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              begin_copy;
  logic              last_ok;

  assign begin_copy = start && (state_q == S_IDLE || state_q == S_ERR);

`ifdef BOOT_CHECKSUM_EN
  logic [11:0] sum_q, sum_d;
  logic [11:0] sum_next;

  // The word being acknowledged is included before the final compare.
  assign sum_next = sum_q + data_q;
  assign last_ok  = (sum_next == CHECKSUM);

  always_comb begin
    sum_d = sum_q;
    if (begin_copy) begin
      sum_d = '0;
    end else if (state_q == S_WRITE && bus.ram_ack) begin
      sum_d = sum_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`else
  assign last_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          idx_d   = '0;
          state_d = (LEN == 0) ? S_RUN : S_READ;
        end
      end
      S_READ: begin
        data_d  = bus.rom_data;
        wait_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.ram_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = last_ok ? S_RUN : S_ERR;
          end else begin
            idx_d   = idx_q + 12'd1;
            state_d = S_READ;
          end
        end else if (wait_q == WAIT_LAST) begin
          // The TIMEOUT-th unacknowledged cycle aborts the copy.
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend on state only, so an async reset clears them at once.
  always_comb begin
    bus.rom_rd   = 1'b0;
    bus.rom_addr = '0;
    bus.ram_wr   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_data = '0;
    busy         = 1'b0;
    cpu_run      = 1'b0;
    cpu_pc       = '0;
    error        = 1'b0;
    unique case (state_q)
      S_READ: begin
        bus.rom_rd   = 1'b1;
        bus.rom_addr = SRC_BASE + {3'b000, idx_q};
        busy         = 1'b1;
      end
      S_WRITE: begin
        bus.ram_wr   = 1'b1;
        bus.ram_addr = DST_BASE + {3'b000, idx_q};
        bus.ram_data = data_q;
        busy         = 1'b1;
      end
      S_RUN: begin
        cpu_run = 1'b1;
        cpu_pc  = START_PC;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.rom_rd && bus.ram_wr));

  a_pc_only_when_run: assert property (@(posedge clk) disable iff (!reset_n)
    (!cpu_run) |-> (cpu_pc == 15'd0));

endmodule
